seq_serializer: RTL and testbench

Parallel-to-serial front end for the sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, onto the detector's serial input. A one-word holding register lets words stream back-to-back with no idle bit between them. It drives 0 on the serial line when it has no data.

---
 rtl/seq_serializer.sv | 131 +++++++++++++
 tb/tb_seq_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bit stream out.
// Define SER_PARITY_EN to append one even-parity bit after each word's LSB.
module seq_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             hold_full, hold_full_d;
  logic             accept, last, load_en;
  logic [WIDTH-1:0] load_word;

  assign din_ready = ~hold_full;
  assign accept    = din_valid & din_ready;
  assign last      = (cnt == LAST_CNT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state;
    sh_d        = sh;
    cnt_d       = cnt;
    hold_d      = hold;
    hold_full_d = hold_full;
    load_en     = 1'b0;
    load_word   = din;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load_en     = 1'b1;
          load_word   = hold;
          hold_full_d = 1'b0;
        end else if (accept) begin
          load_en = 1'b1;
        end
      end
      SHIFT: begin
        if (!last) begin
          sh_d  = {sh[WIDTH-2:0], 1'b0};
          cnt_d = cnt + CW'(1);
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full) begin
          // Hold has priority; din_ready is low here so no accept can collide.
          load_en     = 1'b1;
          load_word   = hold;
          hold_full_d = 1'b0;
        end else if (accept) begin
          load_en = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_en) begin
      sh_d    = load_word;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_d;
      sh        <= sh_d;
      cnt       <= cnt_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
    end
  end

`ifdef SER_PARITY_EN
  logic par;

  // Parity of the word currently in the shifter, captured when it loads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par <= 1'b0;
    end else if (load_en) begin
      par <= ^load_word;
    end
  end

  always_comb begin
    ser_out = 1'b0;
    if (state == SHIFT) begin
      ser_out = (cnt == CW'(WIDTH)) ? par : sh[WIDTH-1];
    end
  end
`else
  assign ser_out = (state == SHIFT) & sh[WIDTH-1];
`endif

  assign ser_valid = (state == SHIFT);
  assign busy      = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: a bit-queue stream model checked every cycle,
// plus literal expected streams for directed words. Honours SER_PARITY_EN.
module tb_seq_serializer;

  localparam int WIDTH = 4;
`ifdef SER_PARITY_EN
  localparam int FL = WIDTH + 1;
  localparam logic [31:0] E_SINGLE = 32'b10111;
  localparam logic [31:0] E_STREAM = 32'b10111_01100_11011;
  localparam logic [31:0] E_STALL  = 32'b11101_00110_01010;
  localparam logic [31:0] E_RST    = 32'b10001;
  localparam logic [31:0] E_1001   = 32'b10010;
`else
  localparam int FL = WIDTH;
  localparam logic [31:0] E_SINGLE = 32'b1011;
  localparam logic [31:0] E_STREAM = 32'b1011_0110_1101;
  localparam logic [31:0] E_STALL  = 32'b1110_0011_0101;
  localparam logic [31:0] E_RST    = 32'b1000;
  localparam logic [31:0] E_1001   = 32'b1001;
`endif

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;

  int errors = 0;
  int checks = 0;

  bit exp_q[$];
  bit capq[$];
  bit m_acc;

  seq_serializer #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: the queue holds every bit still owed on ser_out, head is the bit on the wire.
  // The holding register is occupied exactly when more than one frame is outstanding.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      m_acc = din_valid && (exp_q.size() <= FL);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_acc) begin
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(din[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^din);
`endif
      end
    end
  end

  always @(negedge clock) begin
    check("ser_valid", 32'(ser_valid), 32'(exp_q.size() > 0));
    check("ser_out",   32'(ser_out),   32'((exp_q.size() > 0) ? exp_q[0] : 1'b0));
    check("busy",      32'(busy),      32'(exp_q.size() > 0));
    check("din_ready", 32'(din_ready), 32'(exp_q.size() <= FL));
    if (ser_valid) capq.push_back(ser_out);
  end

  task automatic send(input logic [WIDTH-1:0] w);
    bit done;
    bit r;
    done      = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      r = din_ready;
      @(posedge clock);
      #1;
      done = r;
    end
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clock);
      idle = !ser_valid && !busy;
    end
    check("reached_idle", 32'(idle), 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic expect_stream(input string name, input int base, input int n, input logic [31:0] exp);
    logic [31:0] v;
    v = '0;
    check({name, "_len"}, 32'(capq.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < capq.size()) v = {v[30:0], capq[base + i]};
      else v = {v[30:0], 1'b0};
    end
    check(name, v, exp);
  endtask

  initial begin
    int base;
    reset     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    #1;
    check("rst_ser_out",   32'(ser_out),   32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;

    // Single word: MSB appears right after the accepting edge.
    base = capq.size();
    send(4'b1011);
    din_valid = 1'b0;
    check("single_msb_valid", 32'(ser_valid), 32'd1);
    check("single_msb",       32'(ser_out),   32'd1);
    wait_idle();
    expect_stream("single", base, FL, E_SINGLE);

    // Streaming three words with valid held high.
    base = capq.size();
    send(4'b1011);
    send(4'b0110);
    check("stream_ready_low", 32'(din_ready), 32'd0);
    send(4'b1101);
    din_valid = 1'b0;
    wait_idle();
    expect_stream("stream", base, 3 * FL, E_STREAM);

    // Word stalled while hold is full, kept stable until accepted.
    base = capq.size();
    send(4'b1110);
    send(4'b0011);
    check("stall_ready_low", 32'(din_ready), 32'd0);
    send(4'b0101);
    din_valid = 1'b0;
    wait_idle();
    expect_stream("stall", base, 3 * FL, E_STALL);

    // Mid-frame reset with a word in hold: both discarded.
    send(4'b1110);
    send(4'b0011);
    #2;
    reset     = 1'b0;
    din_valid = 1'b0;
    #1;
    check("mrst_ser_out",   32'(ser_out),   32'd0);
    check("mrst_ser_valid", 32'(ser_valid), 32'd0);
    check("mrst_busy",      32'(busy),      32'd0);
    check("mrst_din_ready", 32'(din_ready), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    base = capq.size();
    send(4'b1000);
    din_valid = 1'b0;
    wait_idle();
    expect_stream("after_reset", base, FL, E_RST);

    // Even-parity zero case.
    base = capq.size();
    send(4'b1001);
    din_valid = 1'b0;
    wait_idle();
    expect_stream("w1001", base, FL, E_1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
